// File: rtl/greedy_snake_dpb_r.sv
// Snake body linked-list reader on Gowin DPB channel B: walks head->NULL,
// streams each node position over valid/ready and flags a query-position hit.
module greedy_snake_dpb_r #(
  parameter bit SKIP_HEAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] list_head_addr,
  input  logic [10:0] list_length,
  input  logic [7:0]  query_pos,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        hit,
  output logic        i_b_clk_en,
  output logic        i_b_data_en,
  output logic        i_b_wr_en,
  output logic [10:0] i_b_address,
  input  logic [7:0]  o_b_data,
  output logic        pos_valid,
  input  logic        pos_ready,
  output logic [7:0]  pos_xy,
  output logic [10:0] pos_index,
  output logic        pos_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [10:0] cur_q, cur_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  query_q, query_d;
  logic [10:0] idx_q, idx_d;
  logic [7:0]  pos_q, pos_d;
  logic [2:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        err_q, err_d;
  logic        hit_q, hit_d;

  logic [10:0] next_addr;
  logic [10:0] idx_inc;
  logic        head_hidden;

  assign next_addr   = {hi_q, lo_q};
  assign idx_inc     = idx_q + 11'd1;
  assign head_hidden = SKIP_HEAD && (idx_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cur_q   <= '0;
      len_q   <= '0;
      query_q <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cur_q   <= cur_d;
      len_q   <= len_d;
      query_q <= query_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cur_d   = cur_q;
    len_d   = len_q;
    query_d = query_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    hit_d   = hit_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = list_head_addr;
          len_d   = list_length;
          query_d = query_pos;
          idx_d   = '0;
          err_d   = 1'b0;
          hit_d   = 1'b0;
          step_d  = '0;
          if (list_head_addr == '0 || list_length == '0) state_d = S_DONE;
          else                                           state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Two-cycle read latency: each byte lands two steps after its address.
        step_d = step_q + 3'd1;
        case (step_q)
          3'd2:    pos_d = o_b_data;
          3'd3:    hi_d  = o_b_data[2:0];
          3'd4: begin
            lo_d    = o_b_data;
            step_d  = '0;
            state_d = S_EMIT;
          end
          default: ;
        endcase
      end
      S_EMIT: begin
        if (pos_ready) begin
          if (pos_q == query_q && !head_hidden) hit_d = 1'b1;
          if (next_addr == '0) begin
            state_d = S_DONE;
          end else if (idx_inc == len_q) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_inc;
            cur_d   = next_addr;
            step_d  = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    i_b_address = '0;
    if (state_q == S_FETCH) begin
      case (step_q)
        3'd0:    i_b_address = cur_q;
        3'd1:    i_b_address = cur_q + 11'd2;
        3'd2:    i_b_address = cur_q + 11'd3;
        default: i_b_address = '0;
      endcase
    end
  end

  assign i_b_clk_en  = 1'b1;
  assign i_b_data_en = 1'b1;
  assign i_b_wr_en   = 1'b0;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign hit       = hit_q;
  assign pos_valid = (state_q == S_EMIT);
  assign pos_xy    = pos_q;
  assign pos_index = idx_q;
  assign pos_last  = (state_q == S_EMIT) && (next_addr == '0);

endmodule

// File: tb/tb_greedy_snake_dpb_r.sv
// Directed bench for greedy_snake_dpb_r: two instances (SKIP_HEAD=1/0) read
// a shared DPB model with two-cycle read latency.
module tb_greedy_snake_dpb_r;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] list_head_addr;
  logic [10:0] list_length;
  logic [7:0]  query_pos;
  logic        pos_ready;

  logic        busy, done, err, hit;
  logic        i_b_clk_en, i_b_data_en, i_b_wr_en;
  logic [10:0] i_b_address;
  logic [7:0]  o_b_data;
  logic        pos_valid, pos_last;
  logic [7:0]  pos_xy;
  logic [10:0] pos_index;

  logic        z_busy, z_done, z_err, z_hit;
  logic        z_clk_en, z_data_en, z_wr_en;
  logic [10:0] z_address;
  logic [7:0]  z_data;
  logic        z_valid, z_last;
  logic [7:0]  z_xy;
  logic [10:0] z_index;

  logic [7:0]  mem [0:2047];
  logic [7:0]  s1, s2, zs1, zs2;

  int nrun = 0;
  int nfail = 0;

  int   nbeats, done_cyc, busy_low, ndone, stall_bad, z_ndone;
  int   beat_cyc  [0:7];
  logic [7:0]  beat_xy   [0:7];
  logic [10:0] beat_idx  [0:7];
  logic        beat_last [0:7];
  logic err_d, hit_d, z_hit_d;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_b_clk_en) begin
      s1 <= mem[i_b_address];
      if (i_b_data_en) s2 <= s1;
    end
    if (z_clk_en) begin
      zs1 <= mem[z_address];
      if (z_data_en) zs2 <= zs1;
    end
  end
  assign o_b_data = s2;
  assign z_data   = zs2;

  greedy_snake_dpb_r #(.SKIP_HEAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .list_head_addr(list_head_addr), .list_length(list_length), .query_pos(query_pos),
    .busy(busy), .done(done), .err(err), .hit(hit),
    .i_b_clk_en(i_b_clk_en), .i_b_data_en(i_b_data_en), .i_b_wr_en(i_b_wr_en),
    .i_b_address(i_b_address), .o_b_data(o_b_data),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_xy(pos_xy),
    .pos_index(pos_index), .pos_last(pos_last)
  );

  greedy_snake_dpb_r #(.SKIP_HEAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .list_head_addr(list_head_addr), .list_length(list_length), .query_pos(query_pos),
    .busy(z_busy), .done(z_done), .err(z_err), .hit(z_hit),
    .i_b_clk_en(z_clk_en), .i_b_data_en(z_data_en), .i_b_wr_en(z_wr_en),
    .i_b_address(z_address), .o_b_data(z_data),
    .pos_valid(z_valid), .pos_ready(pos_ready), .pos_xy(z_xy),
    .pos_index(z_index), .pos_last(z_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nrun++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic put_node(input logic [10:0] a, input logic [7:0] xy, input logic [10:0] nxt);
    mem[a]         = xy;
    mem[a + 11'd1] = 8'hEE;
    mem[a + 11'd2] = {5'b10101, nxt[10:8]};
    mem[a + 11'd3] = nxt[7:0];
  endtask

  // Starts a walk and watches it cycle by cycle (cycle 1 = first after the start edge).
  task automatic walk(input logic [10:0] head, input logic [10:0] len, input logic [7:0] q,
                      input int stall_beat, input int stall_len);
    int cyc;
    int scnt;
    logic [7:0]  sxy;
    logic [10:0] sidx;
    nbeats = 0; done_cyc = -1; busy_low = -1; ndone = 0; z_ndone = 0;
    stall_bad = 0; scnt = 0; sxy = '0; sidx = '0;
    err_d = 1'bx; hit_d = 1'bx; z_hit_d = 1'bx;
    list_head_addr = head; list_length = len; query_pos = q;
    start = 1'b1; pos_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    list_head_addr = 11'h7FF; list_length = 11'd1; query_pos = 8'hFF;
    cyc = 1;
    while (cyc < 400 && busy_low < 0) begin
      if (pos_valid && nbeats == stall_beat && scnt < stall_len) begin
        if (scnt == 0) begin
          sxy = pos_xy; sidx = pos_index;
        end else if (pos_xy !== sxy || pos_index !== sidx) begin
          stall_bad++;
        end
        if (i_b_address !== 11'd0) stall_bad++;
        pos_ready = 1'b0;
        scnt++;
      end else begin
        pos_ready = 1'b1;
      end
      if (pos_valid && pos_ready && nbeats < 8) begin
        beat_cyc[nbeats]  = cyc;
        beat_xy[nbeats]   = pos_xy;
        beat_idx[nbeats]  = pos_index;
        beat_last[nbeats] = pos_last;
        nbeats++;
      end
      if (done) begin
        ndone++; done_cyc = cyc; err_d = err; hit_d = hit;
      end
      if (z_done) begin
        z_ndone++; z_hit_d = z_hit;
      end
      if (!busy && done_cyc >= 0) busy_low = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    pos_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    put_node(11'd4,  8'h44, 11'd8);
    put_node(11'd8,  8'h34, 11'd12);
    put_node(11'd12, 8'h24, 11'd0);
    rst_n = 1'b0; start = 1'b0; pos_ready = 1'b1;
    list_head_addr = '0; list_length = '0; query_pos = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_valid",  {31'd0, pos_valid}, 32'd0);
    chk("rst_addr",   {21'd0, i_b_address}, 32'd0);
    chk("rst_clken",  {30'd0, i_b_clk_en, i_b_data_en}, 32'd3);
    chk("rst_wren",   {31'd0, i_b_wr_en}, 32'd0);
    chk("rst_errhit", {30'd0, err, hit}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset-snake layout, query on node 1.
    walk(11'd4, 11'd3, 8'h34, -1, 0);
    chk("t1_nbeats", nbeats, 3);
    chk("t1_c0", beat_cyc[0], 6);
    chk("t1_c1", beat_cyc[1], 12);
    chk("t1_c2", beat_cyc[2], 18);
    chk("t1_xy", {8'd0, beat_xy[0], beat_xy[1], beat_xy[2]}, 32'h00443424);
    chk("t1_idx0", {21'd0, beat_idx[0]}, 32'd0);
    chk("t1_idx1", {21'd0, beat_idx[1]}, 32'd1);
    chk("t1_idx2", {21'd0, beat_idx[2]}, 32'd2);
    chk("t1_last", {29'd0, beat_last[0], beat_last[1], beat_last[2]}, 32'd1);
    chk("t1_done_cyc", done_cyc, 19);
    chk("t1_ndone", ndone, 1);
    chk("t1_busy_low", busy_low, 20);
    chk("t1_err", {31'd0, err_d}, 32'd0);
    chk("t1_hit", {31'd0, hit_d}, 32'd1);
    chk("t1_hit_noskip", {31'd0, z_hit_d}, 32'd1);
    chk("t1_hit_held", {31'd0, hit}, 32'd1);

    // Query the head position: hidden with SKIP_HEAD=1, visible with SKIP_HEAD=0.
    walk(11'd4, 11'd3, 8'h44, -1, 0);
    chk("t2_hit_skip",   {31'd0, hit_d}, 32'd0);
    chk("t2_hit_noskip", {31'd0, z_hit_d}, 32'd1);
    chk("t2_z_ndone", z_ndone, 1);

    // Ready held low for 5 cycles on beat 1.
    walk(11'd4, 11'd3, 8'h24, 1, 5);
    chk("t3_nbeats", nbeats, 3);
    chk("t3_c1", beat_cyc[1], 17);
    chk("t3_xy1", {24'd0, beat_xy[1]}, 32'h34);
    chk("t3_c2", beat_cyc[2], 23);
    chk("t3_stall_bad", stall_bad, 0);
    chk("t3_done_cyc", done_cyc, 24);
    chk("t3_hit", {31'd0, hit_d}, 32'd1);

    // Cycle 4 -> 8 -> 4 with length 3.
    put_node(11'd8, 8'h34, 11'd4);
    walk(11'd4, 11'd3, 8'h11, -1, 0);
    chk("t4_nbeats", nbeats, 3);
    chk("t4_xy", {8'd0, beat_xy[0], beat_xy[1], beat_xy[2]}, 32'h00443444);
    chk("t4_last", {29'd0, beat_last[0], beat_last[1], beat_last[2]}, 32'd0);
    chk("t4_idx2", {21'd0, beat_idx[2]}, 32'd2);
    chk("t4_done_cyc", done_cyc, 19);
    chk("t4_err", {31'd0, err_d}, 32'd1);
    chk("t4_err_held", {31'd0, err}, 32'd1);
    chk("t4_hit", {31'd0, hit_d}, 32'd0);
    put_node(11'd8, 8'h34, 11'd12);

    // Empty list: head 0, then length 0.
    walk(11'd0, 11'd3, 8'h44, -1, 0);
    chk("t5a_done_cyc", done_cyc, 1);
    chk("t5a_nbeats", nbeats, 0);
    chk("t5a_busy_low", busy_low, 2);
    chk("t5a_err", {31'd0, err_d}, 32'd0);
    walk(11'd4, 11'd0, 8'h44, -1, 0);
    chk("t5b_done_cyc", done_cyc, 1);
    chk("t5b_nbeats", nbeats, 0);
    chk("t5b_busy_low", busy_low, 2);

    // Reset pulsed during FETCH of node 1 (cycles 7..11).
    list_head_addr = 11'd4; list_length = 11'd3; query_pos = 8'h34;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("t6_pre_xy", {24'd0, pos_xy}, 32'h44);
    chk("t6_pre_idx", {21'd0, pos_index}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_xy", {24'd0, pos_xy}, 32'd0);
    chk("t6_idx", {21'd0, pos_index}, 32'd0);
    chk("t6_addr", {21'd0, i_b_address}, 32'd0);
    chk("t6_outs", {27'd0, done, pos_valid, pos_last, err, hit}, 32'd0);
    chk("t6_en", {30'd0, i_b_clk_en, i_b_data_en}, 32'd3);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || pos_valid || busy) ndone++;
    end
    chk("t6_quiet", ndone, 0);
    walk(11'd4, 11'd3, 8'h24, -1, 0);
    chk("t6_nbeats", nbeats, 3);
    chk("t6_xy", {8'd0, beat_xy[0], beat_xy[1], beat_xy[2]}, 32'h00443424);
    chk("t6_c0", beat_cyc[0], 6);
    chk("t6_done_cyc", done_cyc, 19);
    chk("t6_hit", {31'd0, hit_d}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
